// File: rtl/uart_fifo_ctrl.sv
// Sequences TX FIFO pops into UART starts, commits received bytes to the RX FIFO, keeps sticky error flags.
// Define UART_CTRL_STATS_EN to build the saturating frame/drop counters; otherwise they read 0.
module uart_fifo_ctrl #(
  parameter int GAP_CLKS     = 868,
  parameter int BUSY_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_enable,
  input  logic             err_clr,
  input  logic             tx_fifo_empty,
  input  logic             tx_busy,
  output logic             tx_rd_en,
  output logic             start_TX,
  input  logic             eoc_flag,
  input  logic             rx_fifo_full,
  output logic             rx_wr_en,
  output logic             tx_error,
  output logic             rx_overflow,
  output logic             ctrl_idle,
  output logic [CNT_W-1:0] tx_frame_count,
  output logic [CNT_W-1:0] rx_drop_count
);

  localparam int MAXC = (GAP_CLKS > BUSY_TIMEOUT) ? GAP_CLKS : BUSY_TIMEOUT;
  localparam int TW   = $clog2(MAXC + 1) + 1;

  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          timeout;
  logic          rx_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One shared counter: timeout length in WAIT_BUSY, gap length in GAP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_enable && !tx_fifo_empty && !tx_busy) state_nxt = POP;
      end
      POP:   state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: begin
        state_nxt = WAIT_BUSY;
        cnt_nxt   = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt + 1'b1 == TW'(BUSY_TIMEOUT)) begin
          timeout   = 1'b1;
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if ((GAP_CLKS == 0) || (cnt == TW'(GAP_CLKS - 1))) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_rd_en  = (state == POP);
  assign start_TX  = (state == START);
  assign ctrl_idle = (state == IDLE);
  assign rx_drop   = eoc_flag && rx_fifo_full;

  // A new error event takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_en    <= 1'b0;
      tx_error    <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_wr_en <= eoc_flag && !rx_fifo_full;
      if (timeout)      tx_error <= 1'b1;
      else if (err_clr) tx_error <= 1'b0;
      if (rx_drop)      rx_overflow <= 1'b1;
      else if (err_clr) rx_overflow <= 1'b0;
    end
  end

`ifdef UART_CTRL_STATS_EN
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (start_TX && (frame_cnt != {CNT_W{1'b1}})) frame_cnt <= frame_cnt + 1'b1;
      if (rx_drop && (drop_cnt != {CNT_W{1'b1}}))   drop_cnt  <= drop_cnt + 1'b1;
    end
  end

  assign tx_frame_count = frame_cnt;
  assign rx_drop_count  = drop_cnt;
`else
  assign tx_frame_count = '0;
  assign rx_drop_count  = '0;
`endif

endmodule
